cpu_trace_emitter: RTL

CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

---
 rtl/cpu_trace_emitter_pkg.sv | 40 ++++
 rtl/dec_digits.sv | 26 ++
 rtl/cpu_trace_emitter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_emitter_pkg.sv
// Shared types and constants for the trace emitter: state encoding,
// ASCII punctuation, and the nibble-to-hex-character helper.
package cpu_trace_emitter_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CARET,
      ST_TIME,
      ST_AT,
      ST_PC,
      ST_COLON_SP,
      ST_MARK,
      ST_GRF,
      ST_ADDR,
      ST_ARROW,
      ST_DATA,
      ST_HASH
   } state_t;

   localparam logic [7:0] CH_CARET  = 8'h5e;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3a;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2a;
   localparam logic [7:0] CH_LT     = 8'h3c;
   localparam logic [7:0] CH_EQ     = 8'h3d;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_ZERO   = 8'h30;

   // Decimal fields never exceed 9999, so 14 bits always suffice.
   localparam int unsigned DEC_W    = 14;
   localparam logic [31:0] TIME_MAX = 32'd9999;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      // 'a' - 10 = 8'h57
      return (nib < 4'd10) ? (CH_ZERO + {4'h0, nib}) : (8'h57 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/dec_digits.sv
// Combinational binary-to-BCD for values up to 9999: four digits
// (least significant in bcd[3:0]) plus the count of printed digits.
module dec_digits
   import cpu_trace_emitter_pkg::*;
(
   input  logic [DEC_W-1:0] value,
   output logic [15:0]      bcd,
   output logic [2:0]       ndig
);

   always_comb begin
      bcd[3:0]   = 4'(value % DEC_W'(10));
      bcd[7:4]   = 4'((value / DEC_W'(10)) % DEC_W'(10));
      bcd[11:8]  = 4'((value / DEC_W'(100)) % DEC_W'(10));
      bcd[15:12] = 4'((value / DEC_W'(1000)) % DEC_W'(10));
      if (value >= DEC_W'(1000))
         ndig = 3'd4;
      else if (value >= DEC_W'(100))
         ndig = 3'd3;
      else if (value >= DEC_W'(10))
         ndig = 3'd2;
      else
         ndig = 3'd1;
   end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-trace record per accept into an ASCII
// character stream with valid/ready handshake on both sides.
//
// state       | meaning
// ST_IDLE     | no record held, in_ready=1
// ST_CARET    | presenting '^'
// ST_TIME     | presenting time digit cnt (MS digit first)
// ST_AT       | presenting '@'
// ST_PC       | presenting PC nibble cnt
// ST_COLON_SP | presenting ':' (cnt=1) then ' ' (cnt=0)
// ST_MARK     | presenting '$' or '*'
// ST_GRF      | presenting register digit cnt
// ST_ADDR     | presenting address nibble cnt
// ST_ARROW    | presenting " <= " (cnt 3..0)
// ST_DATA     | presenting data nibble cnt
// ST_HASH     | presenting '#'
module cpu_trace_emitter
   import cpu_trace_emitter_pkg::*;
#(
   parameter int TIME_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_type,
   input  logic [TIME_W-1:0] in_time,
   input  logic [31:0]       in_pc,
   input  logic [4:0]        in_grf,
   input  logic [31:0]       in_addr,
   input  logic [31:0]       in_data,
   output logic [7:0]        char,
   output logic              char_valid,
   input  logic              char_ready
);

   state_t            state, nxt_state;
   logic [2:0]        cnt, nxt_cnt;
   logic [7:0]        nxt_char;

   logic              type_q;
   logic [31:0]       pc_q, addr_q, data_q;
   logic [15:0]       t_bcd_q, g_bcd_q;
   logic [2:0]        t_n_q, g_n_q;

   logic [31:0]       time_ext;
   logic [DEC_W-1:0]  time_clamp, grf_ext;
   logic [15:0]       t_bcd, g_bcd;
   logic [2:0]        t_n, g_n;

   assign time_ext   = 32'(in_time);
   assign time_clamp = (time_ext > TIME_MAX) ? DEC_W'(TIME_MAX) : time_ext[DEC_W-1:0];
   assign grf_ext    = DEC_W'(in_grf);

   dec_digits u_dec_time (.value(time_clamp), .bcd(t_bcd), .ndig(t_n));
   dec_digits u_dec_grf  (.value(grf_ext),    .bcd(g_bcd), .ndig(g_n));

   assign in_ready = (state == ST_IDLE);

   // cnt is a down-counter over the characters of multi-character fields.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      case (state)
         ST_CARET: begin
            nxt_state = ST_TIME;
            nxt_cnt   = t_n_q - 3'd1;
         end
         ST_TIME:
            if (cnt == 3'd0) nxt_state = ST_AT;
            else             nxt_cnt   = cnt - 3'd1;
         ST_AT: begin
            nxt_state = ST_PC;
            nxt_cnt   = 3'd7;
         end
         ST_PC:
            if (cnt == 3'd0) begin
               nxt_state = ST_COLON_SP;
               nxt_cnt   = 3'd1;
            end else nxt_cnt = cnt - 3'd1;
         ST_COLON_SP:
            if (cnt == 3'd0) nxt_state = ST_MARK;
            else             nxt_cnt   = cnt - 3'd1;
         ST_MARK:
            if (type_q) begin
               nxt_state = ST_ADDR;
               nxt_cnt   = 3'd7;
            end else begin
               nxt_state = ST_GRF;
               nxt_cnt   = g_n_q - 3'd1;
            end
         ST_GRF, ST_ADDR:
            if (cnt == 3'd0) begin
               nxt_state = ST_ARROW;
               nxt_cnt   = 3'd3;
            end else nxt_cnt = cnt - 3'd1;
         ST_ARROW:
            if (cnt == 3'd0) begin
               nxt_state = ST_DATA;
               nxt_cnt   = 3'd7;
            end else nxt_cnt = cnt - 3'd1;
         ST_DATA:
            if (cnt == 3'd0) nxt_state = ST_HASH;
            else             nxt_cnt   = cnt - 3'd1;
         ST_HASH: begin
            nxt_state = ST_IDLE;
            nxt_cnt   = 3'd0;
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_cnt   = 3'd0;
         end
      endcase
   end

   always_comb begin
      nxt_char = 8'h00;
      case (nxt_state)
         ST_CARET:    nxt_char = CH_CARET;
         ST_TIME:     nxt_char = CH_ZERO + {4'h0, t_bcd_q[{nxt_cnt[1:0], 2'b00} +: 4]};
         ST_AT:       nxt_char = CH_AT;
         ST_PC:       nxt_char = hex_ascii(pc_q[{nxt_cnt, 2'b00} +: 4]);
         ST_COLON_SP: nxt_char = nxt_cnt[0] ? CH_COLON : CH_SPACE;
         ST_MARK:     nxt_char = type_q ? CH_STAR : CH_DOLLAR;
         ST_GRF:      nxt_char = CH_ZERO + {4'h0, g_bcd_q[{nxt_cnt[1:0], 2'b00} +: 4]};
         ST_ADDR:     nxt_char = hex_ascii(addr_q[{nxt_cnt, 2'b00} +: 4]);
         ST_ARROW:
            case (nxt_cnt)
               3'd2:    nxt_char = CH_LT;
               3'd1:    nxt_char = CH_EQ;
               default: nxt_char = CH_SPACE;
            endcase
         ST_DATA:     nxt_char = hex_ascii(data_q[{nxt_cnt, 2'b00} +: 4]);
         ST_HASH:     nxt_char = CH_HASH;
         default:     nxt_char = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= 3'd0;
         char       <= 8'h00;
         char_valid <= 1'b0;
         type_q     <= 1'b0;
         pc_q       <= 32'h0;
         addr_q     <= 32'h0;
         data_q     <= 32'h0;
         t_bcd_q    <= 16'h0;
         g_bcd_q    <= 16'h0;
         t_n_q      <= 3'd0;
         g_n_q      <= 3'd0;
      end else if (state == ST_IDLE) begin
         if (in_valid) begin
            type_q     <= in_type;
            pc_q       <= in_pc;
            addr_q     <= in_addr;
            data_q     <= in_data;
            t_bcd_q    <= t_bcd;
            g_bcd_q    <= g_bcd;
            t_n_q      <= t_n;
            g_n_q      <= g_n;
            state      <= ST_CARET;
            cnt        <= 3'd0;
            char       <= CH_CARET;
            char_valid <= 1'b1;
         end
      end else if (char_valid && char_ready) begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         char       <= nxt_char;
         char_valid <= (nxt_state != ST_IDLE);
      end
   end

endmodule
